moisture_sampler: RTL and testbench
===================================

MOISTURE_SAMPLER -- requirements
Module: moisture_sampler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per adc_sclk half-period; legal range 1..255.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1000: clk cycles between frame starts; legal minimum CLK_DIV*33+2.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  allows new conversion frames to start.
REQ-006 SHALL have port adc_miso  input  1  serial data from the external 10-bit ADC.
REQ-007 SHALL have port adc_sclk  output  1  ADC serial clock; idles low.
REQ-008 SHALL have port adc_cs_n  output  1  ADC chip select, active-low; idles high.
REQ-009 SHALL have port m_sense  output  7  filtered moisture level for the downstream watering FSM.
REQ-010 SHALL have port m_valid  output  1  high once the averaging window holds 4 samples.
REQ-011 SHALL have port sample_strobe  output  1  one-cycle pulse on each m_sense update.

Function
REQ-012 SHALL implement frame FSM states IDLE, SETUP, SHIFT, DONE.
REQ-013 SHALL run a period counter while enable=1, and SHALL leave IDLE for SETUP:
- on the first clk edge after reset release with enable=1;
- thereafter every SAMPLE_PERIOD cycles, measured between adc_cs_n falling edges.
REQ-014 SETUP SHALL drive adc_cs_n=0 with adc_sclk=0 for CLK_DIV cycles, then enter SHIFT.
REQ-015 SHIFT SHALL generate 16 adc_sclk pulses, each CLK_DIV cycles high followed by CLK_DIV cycles low; frame length with cs_n low SHALL be CLK_DIV*33 cycles.
REQ-016 SHALL sample adc_miso on the clk edge at which adc_sclk goes 0->1.
REQ-017 SHALL interpret bit positions as follows (k = 0..15, in order sampled):
- k=0..2: ignored;
- k=3..12: 10-bit sample, MSB first;
- k=13..15: ignored.
REQ-018 After the 16th low phase, adc_cs_n SHALL return high and the FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-019 In DONE, SHALL shift the sample into a 4-entry sliding window, replacing the oldest entry.
REQ-020 Also in DONE, SHALL recompute a 12-bit unsigned sum of the window.
REQ-021 m_sense SHALL equal sum[11:5], registered, updated on the cycle after DONE, with sample_strobe=1 in that same cycle.
REQ-022 m_sense SHALL hold 7'd127 (moist, no watering) until m_valid=1; m_valid SHALL rise together with the 4th sample_strobe after reset and stay high.
REQ-023 If enable drops mid-frame, the frame SHALL complete, including its strobe; no new frame SHALL start until enable=1.
REQ-024 On enable rising, the first new frame SHALL start on the next clk edge, and the period counter SHALL restart from that frame.
REQ-025 If a period elapses while a frame is active (illegal SAMPLE_PERIOD), the new frame SHALL start immediately after DONE; frames SHALL never overlap or be dropped mid-shift.
REQ-026 adc_sclk and adc_cs_n SHALL be driven directly from flops (glitch-free).

Reset
REQ-027 While rst=1, outputs SHALL immediately be:
- adc_cs_n=1, adc_sclk=0;
- m_sense=7'd127, m_valid=0, sample_strobe=0;
- FSM=IDLE, period counter=0, window cleared.
REQ-028 rst asserted mid-frame SHALL abort the frame asynchronously; the partial sample SHALL be discarded.

Verification
REQ-029 Reset: rst=1 -> cs_n=1, sclk=0, m_sense=127, m_valid=0; hold rst 5 cycles, no sclk activity.
REQ-030 Constant ADC model value 10'd720, defaults -> 4 strobes, then m_valid=1 and m_sense=90; m_sense=127 before the 4th strobe.
REQ-031 Step: window of 720 then ADC=1023 -> next strobe m_sense=99 (sum 3183); after 4 frames m_sense=127. ADC=0 for 4 frames -> m_sense=0.
REQ-032 Timing, CLK_DIV=4, SAMPLE_PERIOD=1000 ->
- cs_n low 132 cycles;
- 16 sclk pulses of 4 high / 4 low;
- cs_n falling edges 1000 cycles apart;
- ignored bits k=0..2 and k=13..15 do not affect m_sense.
REQ-033 enable dropped at 8th sclk pulse -> frame completes with strobe; no cs_n falling while enable=0; frame starts one cycle after enable returns.
REQ-034 rst pulsed at 10th sclk pulse -> cs_n=1 and sclk=0 in the same cycle; m_valid=0, m_sense=127; m_valid next rises only after 4 fresh frames.

Source files
------------

// File: rtl/moisture_sampler.sv
// Periodic soil-moisture sampler: reads a 10-bit serial ADC in 16-clock frames
// and presents a 4-sample moving average, scaled to 7 bits, to the watering FSM.
module moisture_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       adc_miso,
    output logic       adc_sclk,
    output logic       adc_cs_n,
    output logic [6:0] m_sense,
    output logic       m_valid,
    output logic       sample_strobe,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int              PW       = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [PW-1:0]   PER_LAST = PW'(SAMPLE_PERIOD - 1);

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [3:0]    bit_k;
    logic          sclk_d, cs_n_d;
    logic          sample_en;
    logic          frame_start;
    logic          div_end;

    logic [PW-1:0] per_q;
    logic          run_q;
    logic          pending_q;
    logic          period_hit;
    logic          start_req;

    logic [9:0]    shreg_q;
    logic [9:0]    win_q [4];
    logic [11:0]   sum_q, sum_d;
    logic [2:0]    cnt_q;
    logic          valid_d;

    // run_q marks a live period count; a cleared count means "start on the next edge".
    assign period_hit = run_q && (per_q == PER_LAST);
    assign start_req  = enable && (!run_q || period_hit || pending_q);
    assign div_end    = (div_q == DIV_LAST);
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        div_d       = '0;
        bit_d       = bit_q;
        bit_k       = bit_q;
        sclk_d      = adc_sclk;
        cs_n_d      = adc_cs_n;
        sample_en   = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d     = SETUP;
                    cs_n_d      = 1'b0;
                    frame_start = 1'b1;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_d   = SHIFT;
                    sclk_d    = 1'b1;
                    bit_d     = 4'd0;
                    bit_k     = 4'd0;
                    sample_en = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else if (adc_sclk) begin
                    sclk_d = 1'b0;
                end else if (bit_q == 4'd15) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                end else begin
                    sclk_d    = 1'b1;
                    bit_d     = bit_q + 4'd1;
                    bit_k     = bit_q + 4'd1;
                    sample_en = 1'b1;
                end
            end
            DONE: begin
                // A period that expired mid-frame chains straight into the next frame.
                if (start_req) begin
                    state_d     = SETUP;
                    cs_n_d      = 1'b0;
                    frame_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            adc_sclk <= 1'b0;
            adc_cs_n <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            adc_sclk <= sclk_d;
            adc_cs_n <= cs_n_d;
        end
    end

    // Only bit slots 3..12 carry the conversion result, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (sample_en && (bit_k >= 4'd3) && (bit_k <= 4'd12)) begin
            shreg_q <= {shreg_q[8:0], adc_miso};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q     <= '0;
            run_q     <= 1'b0;
            pending_q <= 1'b0;
        end else if (frame_start) begin
            per_q     <= '0;
            run_q     <= 1'b1;
            pending_q <= 1'b0;
        end else if (!enable) begin
            per_q     <= '0;
            run_q     <= 1'b0;
            pending_q <= 1'b0;
        end else if (run_q) begin
            if (period_hit) begin
                pending_q <= 1'b1;
            end else begin
                per_q <= per_q + PW'(1);
            end
        end
    end

    // Running sum: add the newest sample, drop the oldest; never exceeds 4*1023.
    assign sum_d   = sum_q + {2'b00, shreg_q} - {2'b00, win_q[3]};
    assign valid_d = m_valid || (cnt_q == 3'd3);

    // m_sense/m_valid are level outputs; sample_strobe pulses for exactly one
    // cycle with each new m_sense value and the consumer needs no ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            sum_q         <= '0;
            cnt_q         <= '0;
            m_valid       <= 1'b0;
            m_sense       <= 7'd127;
            sample_strobe <= 1'b0;
        end else if (state_q == DONE) begin
            win_q[0]      <= shreg_q;
            win_q[1]      <= win_q[0];
            win_q[2]      <= win_q[1];
            win_q[3]      <= win_q[2];
            sum_q         <= sum_d;
            cnt_q         <= (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
            m_valid       <= valid_d;
            m_sense       <= valid_d ? sum_d[11:5] : 7'd127;
            sample_strobe <= 1'b1;
        end else begin
            sample_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moisture_sampler.sv
// Bench for moisture_sampler: serial ADC model, per-frame expectation queue
// checked on every sample_strobe, plus a frame-timing monitor.
module tb_moisture_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       adc_miso;
    logic       adc_sclk;
    logic       adc_cs_n;
    logic [6:0] m_sense;
    logic       m_valid;
    logic       sample_strobe;
    logic [1:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    moisture_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .adc_miso      (adc_miso),
        .adc_sclk      (adc_sclk),
        .adc_cs_n      (adc_cs_n),
        .m_sense       (m_sense),
        .m_valid       (m_valid),
        .sample_strobe (sample_strobe),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- ADC model: junk bits around the 10-bit value ----------------
    logic [9:0]  adc_val = 10'd720;
    logic [15:0] adc_frame = '0;
    int          adc_idx = 16;

    always @(negedge adc_cs_n) begin
        adc_frame = {3'($urandom_range(0, 7)), adc_val, 3'($urandom_range(0, 7))};
        adc_idx   = 0;
    end

    always @(posedge adc_sclk) begin
        if (adc_idx < 16) adc_idx++;
    end

    assign adc_miso = (adc_idx < 16) ? adc_frame[15 - adc_idx] : 1'b0;

    // ---------------- scoreboard: expectation pushed at each frame start ----------------
    logic [7:0] exp_q[$];
    int         mdl_win[4];
    int         mdl_cnt = 0;
    logic       mdl_cs_p = 1'b1;

    always @(negedge clk) begin : model
        int sum;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) mdl_win[i] = 0;
            mdl_cnt = 0;
        end else if (mdl_cs_p && !adc_cs_n) begin
            mdl_win[3] = mdl_win[2];
            mdl_win[2] = mdl_win[1];
            mdl_win[1] = mdl_win[0];
            mdl_win[0] = int'(adc_val);
            if (mdl_cnt < 4) mdl_cnt++;
            sum = mdl_win[0] + mdl_win[1] + mdl_win[2] + mdl_win[3];
            if (mdl_cnt == 4) exp_q.push_back({1'b1, 7'(sum >> 5)});
            else              exp_q.push_back({1'b0, 7'd127});
        end
        mdl_cs_p = adc_cs_n;
    end

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst && sample_strobe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_m_sense", 32'(m_sense), int'(e[6:0]));
                check("sb_m_valid", 32'(m_valid), int'(e[7]));
            end
        end
    end

    // ---------------- frame timing monitor ----------------
    int   cyc = 0, last_fall = 0, cs_low = 0, hi_cnt = 0, lo_cnt = 0, pulses = 0;
    bit   have_last = 1'b0, in_frame = 1'b0;
    logic cs_p = 1'b1, sclk_p = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 1'b0;
            have_last = 1'b0;
        end else begin
            if (!enable) have_last = 1'b0;
            if (cs_p && !adc_cs_n) begin
                if (have_last) check("cs_fall_period", 32'(cyc - last_fall), 1000);
                last_fall = cyc;
                have_last = 1'b1;
                in_frame  = 1'b1;
                cs_low = 1; lo_cnt = 1; hi_cnt = 0; pulses = 0;
                check("sclk_low_at_cs_fall", 32'(adc_sclk), 0);
            end else if (in_frame && !adc_cs_n) begin
                cs_low++;
                if (adc_sclk && !sclk_p) begin
                    check("sclk_low_width", 32'(lo_cnt), 4);
                    hi_cnt = 1;
                    pulses++;
                end else if (!adc_sclk && sclk_p) begin
                    check("sclk_high_width", 32'(hi_cnt), 4);
                    lo_cnt = 1;
                end else if (adc_sclk) begin
                    hi_cnt++;
                end else begin
                    lo_cnt++;
                end
            end else if (in_frame && adc_cs_n) begin
                check("cs_low_cycles", 32'(cs_low), 132);
                check("sclk_pulses", 32'(pulses), 16);
                check("sclk_last_low", 32'(lo_cnt), 4);
                in_frame = 1'b0;
            end
        end
        cs_p   = adc_cs_n;
        sclk_p = adc_sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_strobes(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!sample_strobe && t < 1500);
            check({tag, "_strobe_seen"}, 32'(sample_strobe), 1);
        end
    endtask

    task automatic wait_cs_fall(input string tag);
        int   t = 0;
        bit   seen = 1'b0;
        logic p;
        p = adc_cs_n;
        while (!seen && t < 1500) begin
            @(negedge clk);
            t++;
            if (p && !adc_cs_n) seen = 1'b1;
            p = adc_cs_n;
        end
        check({tag, "_cs_fall_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_sclk_rises(input int n, input string tag);
        int   t = 0, seen = 0;
        logic p;
        p = adc_sclk;
        while (seen < n && t < 400) begin
            @(negedge clk);
            t++;
            if (adc_sclk && !p) seen++;
            p = adc_sclk;
        end
        check({tag, "_sclk_rises"}, 32'(seen), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(adc_cs_n), 1);
        check({tag, "_sclk"}, 32'(adc_sclk), 0);
        check({tag, "_m_sense"}, 32'(m_sense), 127);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_strobe"}, 32'(sample_strobe), 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int falls;
        logic p;
        rst     = 1'b0;
        enable  = 1'b1;
        adc_val = 10'd720;
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        repeat (5) begin
            @(negedge clk);
            check("por_hold_sclk", 32'(adc_sclk), 0);
            check("por_hold_cs_n", 32'(adc_cs_n), 1);
        end
        rst = 1'b0;

        // constant 720: 4*720 = 2880, >>5 = 90
        wait_strobes(3, "c720");
        check("c720_pre_valid", 32'(m_valid), 0);
        check("c720_pre_sense", 32'(m_sense), 127);
        wait_strobes(1, "c720_4th");
        check("c720_valid", 32'(m_valid), 1);
        check("c720_sense", 32'(m_sense), 90);

        // step to 1023: 3*720+1023 = 3183 -> 99; then 4*1023 = 4092 -> 127
        adc_val = 10'd1023;
        wait_strobes(1, "step1");
        check("step1_sense", 32'(m_sense), 99);
        wait_strobes(3, "step4");
        check("step4_sense", 32'(m_sense), 127);

        adc_val = 10'd0;
        wait_strobes(4, "zero");
        check("zero_sense", 32'(m_sense), 0);

        // enable dropped mid-frame: window 300,0,0,0 -> 9
        adc_val = 10'd300;
        wait_cs_fall("en");
        wait_sclk_rises(8, "en");
        enable = 1'b0;
        wait_strobes(1, "en_finish");
        check("en_finish_sense", 32'(m_sense), 9);
        falls = 0;
        p = adc_cs_n;
        repeat (1500) begin
            @(negedge clk);
            if (p && !adc_cs_n) falls++;
            p = adc_cs_n;
        end
        check("en_low_no_frames", 32'(falls), 0);
        check("en_low_idle", 32'(dbg_state), 0);
        adc_val = 10'd500;
        enable  = 1'b1;
        @(negedge clk);
        check("en_restart_cs_n", 32'(adc_cs_n), 0);
        wait_strobes(1, "en_restart");
        check("en_restart_sense", 32'(m_sense), 25);

        // reset mid-frame at the 10th sclk pulse, then 4 fresh frames of 500 -> 62
        wait_cs_fall("rst");
        wait_sclk_rises(10, "rst");
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (5) begin
            @(negedge clk);
            check("rst_hold_sclk", 32'(adc_sclk), 0);
            check("rst_hold_cs_n", 32'(adc_cs_n), 1);
        end
        rst = 1'b0;
        wait_strobes(3, "rst_refill");
        check("rst_refill_valid", 32'(m_valid), 0);
        check("rst_refill_sense", 32'(m_sense), 127);
        wait_strobes(1, "rst_4th");
        check("rst_4th_valid", 32'(m_valid), 1);
        check("rst_4th_sense", 32'(m_sense), 62);

        repeat (10) @(negedge clk);
        check("sb_queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
